// File: rtl/iob_sync_fifo_asym_lvl.sv
// Single-clock FIFO with independent write/read widths, level reporting, threshold flags,
// sticky overflow/underflow and flush. Define IOB_SYNC_FIFO_ASYM_FWFT_EN for first-word-fall-through reads.
module iob_sync_fifo_asym_lvl #(
    parameter int W_DATA_W  = 8,
    parameter int R_DATA_W  = 32,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = 4,
    parameter int AEMPTY_TH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    output logic                w_afull,
    output logic [ADDR_W:0]     w_level,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic                r_aempty,
    output logic [ADDR_W:0]     r_level,
    output logic                overflow,
    output logic                underflow
);
    localparam int MIN_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int WR    = W_DATA_W / MIN_W;
    localparam int RR    = R_DATA_W / MIN_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [MIN_W-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   w_ptr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     occ;
    logic [ADDR_W:0]     occ_nxt;
    logic                w_acc;
    logic                r_acc;
    logic [R_DATA_W-1:0] head_word;
    int                  occ_i;
    int                  w_words;
    int                  r_words;

    assign w_acc = w_en && !w_full && !clr;
    assign r_acc = r_en && !r_empty && !clr;

    // Flags and levels are registered from the occupancy the FIFO will have after this edge.
    always_comb begin
        occ_nxt = occ;
        if (clr) begin
            occ_nxt = '0;
        end else begin
            occ_nxt = occ + (w_acc ? (ADDR_W+1)'(WR) : '0) - (r_acc ? (ADDR_W+1)'(RR) : '0);
        end
        occ_i   = int'(occ_nxt);
        w_words = (DEPTH - occ_i) / WR;
        r_words = occ_i / RR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            occ       <= '0;
            w_full    <= 1'b0;
            w_afull   <= 1'b0;
            w_level   <= (ADDR_W+1)'(DEPTH / WR);
            r_empty   <= 1'b1;
            r_aempty  <= 1'b1;
            r_level   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            occ      <= occ_nxt;
            w_full   <= (DEPTH - occ_i) < WR;
            w_afull  <= w_words <= AFULL_TH;
            w_level  <= (ADDR_W+1)'(w_words);
            r_empty  <= occ_i < RR;
            r_aempty <= r_words <= AEMPTY_TH;
            r_level  <= (ADDR_W+1)'(r_words);
            if (clr) begin
                w_ptr     <= '0;
                r_ptr     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (w_acc)
                    w_ptr <= w_ptr + ADDR_W'(WR);
                if (r_acc)
                    r_ptr <= r_ptr + ADDR_W'(RR);
                if (w_en && w_full)
                    overflow <= 1'b1;
                if (r_en && r_empty)
                    underflow <= 1'b1;
            end
        end
    end

    // Pointer arithmetic is truncated to ADDR_W bits, so wide accesses straddle the wrap contiguously.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int i = 0; i < WR; i++)
                mem[w_ptr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
        end
    end

    always_comb begin
        head_word = '0;
        for (int i = 0; i < RR; i++)
            head_word[i*MIN_W +: MIN_W] = mem[r_ptr + ADDR_W'(i)];
    end

`ifdef IOB_SYNC_FIFO_ASYM_FWFT_EN
    assign r_data = r_empty ? '0 : head_word;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_data <= '0;
        else if (clr)
            r_data <= '0;
        else if (r_acc)
            r_data <= head_word;
    end
`endif

endmodule
